// File: rtl/morse_pkg.sv
// Shared types and unit durations for the Morse LED scheduler.
// A symbol plays as an ON phase (marks only) followed by an OFF phase.
package morse_pkg;

  typedef enum logic [1:0] {
    SYM_DOT        = 2'd0,
    SYM_DASH       = 2'd1,
    SYM_LETTER_GAP = 2'd2,
    SYM_WORD_GAP   = 2'd3
  } morse_sym_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2
  } morse_state_e;

  localparam logic [2:0] UNITS_DOT        = 3'd1;
  localparam logic [2:0] UNITS_DASH       = 3'd3;
  localparam logic [2:0] UNITS_MARK_GAP   = 3'd1;
  localparam logic [2:0] UNITS_LETTER_GAP = 3'd3;
  localparam logic [2:0] UNITS_WORD_GAP   = 3'd7;

  function automatic logic is_mark(morse_sym_e s);
    return (s == SYM_DOT) || (s == SYM_DASH);
  endfunction

  function automatic logic [2:0] on_units(morse_sym_e s);
    return (s == SYM_DASH) ? UNITS_DASH : UNITS_DOT;
  endfunction

  // OFF length after the symbol: a mark is followed by the one-unit intra-letter gap.
  function automatic logic [2:0] off_units(morse_sym_e s);
    case (s)
      SYM_LETTER_GAP: return UNITS_LETTER_GAP;
      SYM_WORD_GAP:   return UNITS_WORD_GAP;
      default:        return UNITS_MARK_GAP;
    endcase
  endfunction

endpackage

// File: rtl/morse_unit_timer.sv
// Free-running unit timer: counts 0..UNIT_CYCLES-1, ticks on terminal count,
// and returns to 0 whenever restart is asserted.
module morse_unit_timer #(
  parameter int unsigned UNIT_CYCLES = 12_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic tick
);

  localparam int unsigned CW = $clog2(UNIT_CYCLES);
  localparam logic [CW-1:0] TERM = CW'(UNIT_CYCLES - 1);

  logic [CW-1:0] cnt;

  assign tick = (cnt == TERM);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (restart || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/morse_led_sched.sv
// Two-requester Morse symbol player driving one shared LED.
// Round-robin arbiter in IDLE, then ON/OFF phases timed in whole units.
module morse_led_sched
  import morse_pkg::*;
#(
  parameter int unsigned UNIT_CYCLES = 12_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  input  logic [1:0] req0_sym,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [1:0] req1_sym,
  output logic       req1_ready,
  output logic       ledD3,
  output logic       busy,
  output logic       owner
);

  morse_state_e state, state_next;
  morse_sym_e   sym_q, sel_sym;
  logic [2:0]   units, units_next;
  logic         last_served;
  logic         grant, accept, tick, restart;

  // Handshake: a symbol transfers on the rising edge where reqN_valid & reqN_ready;
  // ready is only offered in IDLE to the granted requester, and valid may drop freely.
  always_comb begin
    grant = req1_valid;
    if (req0_valid && req1_valid) grant = ~last_served;
  end

  assign req0_ready = (state == ST_IDLE) && !grant;
  assign req1_ready = (state == ST_IDLE) && grant;
  assign accept     = grant ? (req1_valid && req1_ready) : (req0_valid && req0_ready);
  assign sel_sym    = morse_sym_e'(grant ? req1_sym : req0_sym);
  assign busy       = (state != ST_IDLE);

  always_comb begin
    state_next = state;
    units_next = units;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (is_mark(sel_sym)) begin
            state_next = ST_ON;
            units_next = on_units(sel_sym);
          end else begin
            state_next = ST_OFF;
            units_next = off_units(sel_sym);
          end
        end
      end
      ST_ON: begin
        if (tick) begin
          if (units == 3'd1) begin
            state_next = ST_OFF;
            units_next = off_units(sym_q);
          end else begin
            units_next = units - 3'd1;
          end
        end
      end
      ST_OFF: begin
        if (tick) begin
          if (units == 3'd1) begin
            state_next = ST_IDLE;
            units_next = 3'd0;
          end else begin
            units_next = units - 3'd1;
          end
        end
      end
      default: begin
        state_next = ST_IDLE;
        units_next = 3'd0;
      end
    endcase
  end

  // Holding the timer in restart while idle makes every phase start from cycle 0.
  assign restart = (state_next != state) || (state == ST_IDLE);

  morse_unit_timer #(.UNIT_CYCLES(UNIT_CYCLES)) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (restart),
    .tick    (tick)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      units       <= 3'd0;
      ledD3       <= 1'b0;
      owner       <= 1'b0;
      last_served <= 1'b1;
      sym_q       <= SYM_DOT;
    end else begin
      state <= state_next;
      units <= units_next;
      ledD3 <= (state_next == ST_ON);
      if (accept) begin
        owner       <= grant;
        last_served <= grant;
        sym_q       <= sel_sym;
      end
    end
  end

endmodule

// File: tb/tb_morse_led_sched.sv
// Directed bench for morse_led_sched with UNIT_CYCLES=4; all interaction
// happens 1 time unit after the rising edge.
module tb_morse_led_sched;

  localparam int unsigned U = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0_valid = 1'b0;
  logic [1:0] req0_sym = 2'd0;
  logic       req1_valid = 1'b0;
  logic [1:0] req1_sym = 2'd0;
  logic       req0_ready, req1_ready, ledD3, busy, owner;

  int check_cnt = 0;
  int pass_cnt  = 0;

  morse_led_sched #(.UNIT_CYCLES(U)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_sym   (req0_sym),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_sym   (req1_sym),
    .req1_ready (req1_ready),
    .ledD3      (ledD3),
    .busy       (busy),
    .owner      (owner)
  );

  always #5 clk = ~clk;

  task automatic tick_wait();
    @(posedge clk);
    #1;
  endtask

  // Offer one symbol, let it be accepted, then record n cycles of outputs.
  task automatic play(input bit r, input logic [1:0] sym, input int n,
                      output logic [31:0] led_b, output logic [31:0] busy_b,
                      output logic rdy_pre, output logic rdy_post, output logic own_ok);
    led_b = '0; busy_b = '0; own_ok = 1'b1;
    if (r) begin req1_valid = 1'b1; req1_sym = sym; end
    else begin req0_valid = 1'b1; req0_sym = sym; end
    #1;
    rdy_pre = r ? req1_ready : req0_ready;
    tick_wait();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rdy_post = r ? req1_ready : req0_ready;
    for (int i = 0; i < n; i++) begin
      led_b[i]  = ledD3;
      busy_b[i] = busy;
      if (busy && (owner !== r)) own_ok = 1'b0;
      tick_wait();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_cnt++; if (ledD3 !== 1'b0) $display("FAIL reset_led got=%b exp=0", ledD3); else pass_cnt++;
    check_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else pass_cnt++;
    check_cnt++; if (owner !== 1'b0) $display("FAIL reset_owner got=%b exp=0", owner); else pass_cnt++;
    check_cnt++; if ({req0_ready, req1_ready} !== 2'b10)
      $display("FAIL reset_ready got=%b exp=10", {req0_ready, req1_ready}); else pass_cnt++;
    rst_n = 1'b1;
    tick_wait();
    check_cnt++; if (busy !== 1'b0) $display("FAIL reset_idle_busy got=%b exp=0", busy); else pass_cnt++;
  endtask

  task automatic test_dot();
    logic [31:0] lb, bb; logic rp, rq, ok;
    play(1'b0, 2'd0, 12, lb, bb, rp, rq, ok);
    check_cnt++; if (rp !== 1'b1) $display("FAIL dot_ready_pre got=%b exp=1", rp); else pass_cnt++;
    check_cnt++; if (rq !== 1'b0) $display("FAIL dot_ready_post got=%b exp=0", rq); else pass_cnt++;
    check_cnt++; if (lb !== 32'h0000_000F) $display("FAIL dot_led got=%h exp=%h", lb, 32'h0000_000F); else pass_cnt++;
    check_cnt++; if (bb !== 32'h0000_00FF) $display("FAIL dot_busy got=%h exp=%h", bb, 32'h0000_00FF); else pass_cnt++;
    check_cnt++; if (ok !== 1'b1) $display("FAIL dot_owner got=%b exp=1", ok); else pass_cnt++;
  endtask

  task automatic test_dash();
    logic [31:0] lb, bb; logic rp, rq, ok;
    play(1'b1, 2'd1, 20, lb, bb, rp, rq, ok);
    check_cnt++; if (rp !== 1'b1) $display("FAIL dash_ready_pre got=%b exp=1", rp); else pass_cnt++;
    check_cnt++; if (lb !== 32'h0000_0FFF) $display("FAIL dash_led got=%h exp=%h", lb, 32'h0000_0FFF); else pass_cnt++;
    check_cnt++; if (bb !== 32'h0000_FFFF) $display("FAIL dash_busy got=%h exp=%h", bb, 32'h0000_FFFF); else pass_cnt++;
    check_cnt++; if (ok !== 1'b1) $display("FAIL dash_owner got=%b exp=1", ok); else pass_cnt++;
  endtask

  // Last served is requester 1 here; a req0 valid pulse that misses the edge must not change that.
  task automatic test_glitch();
    req0_valid = 1'b1;
    #2;
    req0_valid = 1'b0;
    tick_wait();
    check_cnt++; if (busy !== 1'b0) $display("FAIL glitch_busy got=%b exp=0", busy); else pass_cnt++;
    req0_valid = 1'b1; req0_sym = 2'd0;
    req1_valid = 1'b1; req1_sym = 2'd0;
    #1;
    check_cnt++; if ({req0_ready, req1_ready} !== 2'b10)
      $display("FAIL glitch_tie got=%b exp=10", {req0_ready, req1_ready}); else pass_cnt++;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tick_wait();
  endtask

  task automatic test_round_robin();
    logic g [4];
    logic g_exp [4];
    int ng = 0;
    int both = 0;
    g_exp = '{1'b0, 1'b1, 1'b0, 1'b1};
    req0_valid = 1'b1; req0_sym = 2'd0;
    req1_valid = 1'b1; req1_sym = 2'd0;
    #1;
    for (int c = 0; c < 60 && ng < 4; c++) begin
      if (req0_ready && req1_ready) both++;
      else if (req0_ready) begin g[ng] = 1'b0; ng++; end
      else if (req1_ready) begin g[ng] = 1'b1; ng++; end
      tick_wait();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    check_cnt++; if (ng !== 4) $display("FAIL rr_timeout got=%0d exp=4", ng); else pass_cnt++;
    check_cnt++; if (both !== 0) $display("FAIL rr_both_ready got=%0d exp=0", both); else pass_cnt++;
    for (int k = 0; k < ng; k++) begin
      check_cnt++; if (g[k] !== g_exp[k]) $display("FAIL rr_grant%0d got=%b exp=%b", k, g[k], g_exp[k]); else pass_cnt++;
    end
    repeat (12) tick_wait();
  endtask

  task automatic test_gaps();
    logic [31:0] lb, bb; logic rp, rq, ok;
    play(1'b0, 2'd3, 32, lb, bb, rp, rq, ok);
    check_cnt++; if (lb !== 32'h0) $display("FAIL word_led got=%h exp=0", lb); else pass_cnt++;
    check_cnt++; if (bb !== 32'h0FFF_FFFF) $display("FAIL word_busy got=%h exp=%h", bb, 32'h0FFF_FFFF); else pass_cnt++;
    play(1'b1, 2'd2, 16, lb, bb, rp, rq, ok);
    check_cnt++; if (lb !== 32'h0) $display("FAIL letter_led got=%h exp=0", lb); else pass_cnt++;
    check_cnt++; if (bb !== 32'h0000_0FFF) $display("FAIL letter_busy got=%h exp=%h", bb, 32'h0000_0FFF); else pass_cnt++;
    check_cnt++; if (ok !== 1'b1) $display("FAIL letter_owner got=%b exp=1", ok); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] lb = '0, bb = '0;
    req0_valid = 1'b1; req0_sym = 2'd0;
    tick_wait();
    for (int i = 0; i < 20; i++) begin
      lb[i] = ledD3;
      bb[i] = busy;
      if (i == 9) req0_valid = 1'b0;
      tick_wait();
    end
    check_cnt++; if (lb !== 32'h0000_1E0F) $display("FAIL b2b_led got=%h exp=%h", lb, 32'h0000_1E0F); else pass_cnt++;
    check_cnt++; if (bb !== 32'h0001_FEFF) $display("FAIL b2b_busy got=%h exp=%h", bb, 32'h0001_FEFF); else pass_cnt++;
  endtask

  task automatic test_sym_change();
    logic [31:0] lb = '0, bb = '0;
    req0_valid = 1'b1; req0_sym = 2'd0;
    tick_wait();
    req0_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      lb[i] = ledD3;
      bb[i] = busy;
      if (i == 1) req0_sym = 2'd1;
      tick_wait();
    end
    check_cnt++; if (lb !== 32'h0000_000F) $display("FAIL symchg_led got=%h exp=%h", lb, 32'h0000_000F); else pass_cnt++;
    check_cnt++; if (bb !== 32'h0000_00FF) $display("FAIL symchg_busy got=%h exp=%h", bb, 32'h0000_00FF); else pass_cnt++;
  endtask

  task automatic test_reset_mid_dash();
    logic [31:0] lb = '0, bb = '0;
    req0_valid = 1'b1; req0_sym = 2'd1;
    tick_wait();
    req0_valid = 1'b0;
    repeat (5) tick_wait();
    check_cnt++; if (ledD3 !== 1'b1) $display("FAIL midrst_on6 got=%b exp=1", ledD3); else pass_cnt++;
    rst_n = 1'b0;
    req0_valid = 1'b1; req0_sym = 2'd0;
    tick_wait();
    check_cnt++; if (ledD3 !== 1'b0) $display("FAIL midrst_led got=%b exp=0", ledD3); else pass_cnt++;
    check_cnt++; if (busy !== 1'b0) $display("FAIL midrst_busy got=%b exp=0", busy); else pass_cnt++;
    check_cnt++; if (req0_ready !== 1'b1) $display("FAIL midrst_ready0 got=%b exp=1", req0_ready); else pass_cnt++;
    req0_valid = 1'b0;
    rst_n = 1'b1;
    tick_wait();
    for (int i = 0; i < 16; i++) begin
      lb[i] = ledD3;
      bb[i] = busy;
      tick_wait();
    end
    check_cnt++; if (lb !== 32'h0) $display("FAIL midrst_replay_led got=%h exp=0", lb); else pass_cnt++;
    check_cnt++; if (bb !== 32'h0) $display("FAIL midrst_replay_busy got=%h exp=0", bb); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_dot();
    test_dash();
    test_glitch();
    test_reset();
    test_round_robin();
    test_gaps();
    test_back_to_back();
    test_sym_change();
    test_reset_mid_dash();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
